byte_write_arbiter: RTL
=======================

# byte_write_arbiter

Round-robin arbiter that shares a single registered 8-bit write datapath (a byte register clocked on the rising edge) among N requesters. Each requester sends a burst of beats over a valid/ready handshake. A grant is locked for the whole burst and released on the last beat, or forcibly after a beat limit. Output is a one-entry registered stage with backpressure, feeding the downstream byte register bank.

## Interface
- N, 4, number of requesters (2..16)
- WIDTH, 8, data width per beat
- MAX_BEATS, 16, beat limit per burst before forced release (1..256)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  N  per-requester beat valid
- in_data  input  N x WIDTH  per-requester beat data (packed, requester i at [i])
- in_last  input  N  per-requester last beat of burst
- in_ready  output  N  per-requester beat accepted this cycle when valid & ready
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accepts the beat
- out_data  output  WIDTH  beat data
- out_last  output  1  beat ends burst (natural or forced)
- out_id  output  $clog2(N)  requester index of beat
- busy  output  1  arbiter in LOCKED state
- overrun  output  1  one-cycle pulse: burst force-released at MAX_BEATS

## Operation
- States: IDLE, LOCKED.
- IDLE: in_ready all 0. If any in_valid, pick the first set bit at or after priority pointer `ptr`, wrapping. Register it as `grant_id`, clear the beat count, go to LOCKED.
- LOCKED: in_ready[grant_id] = !out_valid || out_ready; all other in_ready bits are 0.
- Accepted beat (in_valid[grant_id] & in_ready[grant_id]):
  - Load out_data, out_id = grant_id, out_valid = 1.
  - out_last = in_last[grant_id] || (count == MAX_BEATS-1).
  - Increment the beat count.
- Release on an accepted beat with out_last set:
  - Go to IDLE; ptr = (grant_id+1) mod N.
  - If release was forced (in_last = 0), pulse overrun for one cycle.
  - Remaining beats of that requester re-arbitrate as a new burst.
- Output register: out_valid clears when out_ready is high and no new beat is loaded that cycle. A simultaneous drain and load keeps out_valid = 1 with the new contents.
- Requester drops in_valid while LOCKED: remain LOCKED. No timeout on idle gaps.
- Requesters in_valid not granted: must hold their data; they are not dropped.
- Reset values: state IDLE, ptr 0, count 0, in_ready 0, out_valid 0, out_data 0, out_last 0, out_id 0, busy 0, overrun 0.

## Timing
- Request at cycle t in IDLE: grant registered at t+1 (busy = 1). First beat can be accepted at t+1, and out_valid rises at t+2.
- Throughput in LOCKED with out_ready held high: one beat per cycle.
- Release costs one IDLE cycle per burst, so back-to-back bursts from different requesters have a single bubble.
- rst mid-burst: all state returns to reset values the next edge; the in-flight output beat is discarded.
- MAX_BEATS = 1: every beat releases; only single-beat bursts are supported and overrun pulses on any beat with in_last = 0.

## Structure
- Shared package byte_arb_pkg:
  - state enum (IDLE, LOCKED)
  - default constants for N, WIDTH, MAX_BEATS
- Beat count width: $clog2(MAX_BEATS+1).
- Sub-module rr_pick: combinational masked priority encoder (inputs: request vector, ptr; outputs: found, index), reused by other arbiters.

## Test plan
- Single requester: in_valid[2] with 3 beats 0x11, 0x22, 0x33 (last on 0x33), out_ready = 1. Expect busy at t+1; outputs 0x11, 0x22, 0x33 at t+2..t+4 with out_id = 2 and out_last only on 0x33. Then IDLE, ptr = 3.
- Fairness: all 4 requesters hold single-beat bursts continuously from ptr 0. Expect out_id sequence 0,1,2,3,0, each burst separated by one idle cycle.
- Backpressure: out_ready low for 5 cycles mid-burst. Expect in_ready[grant_id] = 0 while out_valid = 1, data held stable, and no beat lost or duplicated.
- Forced release: MAX_BEATS = 4 and requester 1 streams 6 beats with no in_last. Expect out_last and overrun on beat 4; beats 5–6 re-arbitrated as a new burst.
- Reset mid-burst: assert rst during beat 2 of a 4-beat burst. Expect all outputs at reset values next cycle, then a fresh grant from ptr 0.
- Simultaneous drain and load: out_ready = 1 with a new accepted beat in the same cycle. Expect out_valid stays 1 and out_data updates with no bubble.

Source files
------------

// File: rtl/byte_arb_pkg.sv
// Shared types and default sizing for the byte write arbiter family.
package byte_arb_pkg;

    // Arbiter control state: IDLE picks a requester, LOCKED streams its burst.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_N         = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BEATS = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request bit at or after ptr, wrapping past N-1.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan from the farthest candidate back towards ptr so the nearest one wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/byte_write_arbiter.sv
// Round-robin burst arbiter sharing one registered byte output stage among N requesters.
//
// Handshakes: a beat moves across an interface on a rising clk edge where its
// valid and ready are both high. Input side: only the locked requester ever sees
// in_ready, and in_ready never depends on that requester's own in_valid. Output
// side: out_valid stays high with stable out_data/out_last/out_id until a cycle
// with out_ready high; a new beat may be loaded in that same draining cycle.
module byte_write_arbiter
    import byte_arb_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N-1:0]                in_valid,
    input  logic [N*WIDTH-1:0]          in_data,
    input  logic [N-1:0]                in_last,
    output logic [N-1:0]                in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_last,
    output logic [$clog2(N)-1:0]        out_id,
    output logic                        busy,
    output logic                        overrun
);

    localparam int IW    = $clog2(N);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [IW-1:0]   grant_id;
    logic [IW-1:0]   ptr;
    logic [CNT_W-1:0] count;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;

    logic            lane_ready;
    logic            accept;
    logic            beat_last;
    logic            forced;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next state, per-requester ready and beat accept/terminate decode.
    always_comb begin
        state_nxt  = state;
        in_ready   = '0;
        lane_ready = 1'b0;
        accept     = 1'b0;
        beat_last  = 1'b0;
        forced     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                lane_ready         = !out_valid || out_ready;
                in_ready[grant_id] = lane_ready;
                accept             = in_valid[grant_id] && lane_ready;
                beat_last          = in_last[grant_id] || (count == CNT_W'(MAX_BEATS - 1));
                forced             = !in_last[grant_id];
                if (accept && beat_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control registers: state, locked requester, beat count and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            ptr      <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                grant_id <= pick_idx;
                count    <= '0;
            end else if (accept) begin
                count <= count + CNT_W'(1);
            end
            if (accept && beat_last) begin
                ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
            end
        end
    end

    // One-entry output stage; a load wins over a drain so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= accept && beat_last && forced;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant_id*WIDTH +: WIDTH];
                out_last  <= beat_last;
                out_id    <= grant_id;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == LOCKED);

endmodule
